// File: rtl/vram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_arbiter : screen-RAM port shared by raster fetch and CPU bus.
//                Video wins by default; a starvation guard forces a CPU slot.
// Rev 1.0
// ----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_valid,
  output logic        vid_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  localparam logic [5:0] c_WAIT_MAX = 6'h3F;
  // Limits above the counter range can never be reached, so the guard never fires.
  localparam logic [6:0] c_LIMIT    = (STARVE_LIMIT > 63) ? 7'd64 : 7'(STARVE_LIMIT);
  localparam logic       c_GUARD_ON = (STARVE_LIMIT != 0);

  state_t     r_state;
  state_t     w_state_next;
  tag_t       r_tag0;
  tag_t       r_tag1;
  tag_t       w_issue_tag;
  logic [5:0] r_wait_cnt;
  logic       r_cpu_rd;
  logic       w_starve;
  logic       w_vid_issue;
  logic       w_cpu_issue;

  always_comb begin
    w_starve     = c_GUARD_ON && (r_state == ST_IDLE) && cpu_req &&
                   ({1'b0, r_wait_cnt} >= c_LIMIT);
    w_vid_issue  = vid_req && !w_starve;
    w_cpu_issue  = w_starve || (!vid_req && (r_state == ST_IDLE) && cpu_req);
    w_issue_tag  = TAG_NONE;
    if (w_vid_issue) begin
      w_issue_tag = TAG_VID;
    end else if (w_cpu_issue) begin
      w_issue_tag = TAG_CPU;
    end
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cpu_issue) w_state_next = ST_BUSY;
      ST_BUSY: if (r_tag1 == TAG_CPU) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag0     <= TAG_NONE;
      r_tag1     <= TAG_NONE;
      r_wait_cnt <= '0;
      r_cpu_rd   <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_din    <= '0;
      vid_dout   <= '0;
      vid_valid  <= 1'b0;
      vid_miss   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_be <= 2'b00;
      if (w_vid_issue) begin
        mem_addr <= vid_addr;
        mem_be   <= 2'b11;
      end else if (w_cpu_issue) begin
        mem_addr <= cpu_addr;
        mem_we   <= cpu_we;
        mem_be   <= cpu_be;
        mem_din  <= cpu_wdata;
        r_cpu_rd <= !cpu_we;
      end

      r_tag0 <= w_issue_tag;
      r_tag1 <= r_tag0;

      // mem_dout now holds the word addressed two edges ago; retire its owner.
      vid_valid <= (r_tag1 == TAG_VID);
      cpu_ack   <= (r_tag1 == TAG_CPU);
      if (r_tag1 == TAG_VID) begin
        vid_dout <= mem_dout;
      end
      if ((r_tag1 == TAG_CPU) && r_cpu_rd) begin
        cpu_rdata <= mem_dout;
      end

      vid_miss <= w_starve && vid_req;

      if (!cpu_req || w_cpu_issue) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_IDLE) && (r_wait_cnt != c_WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// tb_vram_arbiter : directed scenarios, then random traffic against a
// transaction-level memory/ordering model.
module tb_vram_arbiter;

  localparam int STARVE = 16;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] vid_dout, cpu_rdata, mem_din, mem_dout;
  logic        vid_valid, vid_miss, cpu_ack, mem_we;
  logic [13:0] mem_addr;
  logic [1:0]  mem_be;

  logic [15:0] vid_dout0, cpu_rdata0, mem_din0, mem_dout0;
  logic        vid_valid0, vid_miss0, cpu_ack0, mem_we0;
  logic [13:0] mem_addr0;
  logic [1:0]  mem_be0;

  logic [15:0] mem [0:16383];
  logic [15:0] shadow [0:15];
  logic [13:0] vq [$];

  int checks = 0;
  int errors = 0;
  int mem_accesses = 0;
  int ack_cnt = 0;
  int miss0_cnt = 0;

  logic       cpu_pend = 1'b0;
  logic       c_we = 1'b0;
  logic [3:0] c_idx = 4'd0;
  logic       acked = 1'b0;
  int         lat = 0;

  vram_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  vram_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout0),
    .vid_valid(vid_valid0), .vid_miss(vid_miss0),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_din(mem_din0),
    .mem_dout(mem_dout0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Synchronous single-port RAM: registered read, byte-lane writes.
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (mem_be != 2'b00) mem_accesses++;
    if (mem_we) begin
      if (mem_be[1]) mem[mem_addr][15:8] = mem_din[15:8];
      if (mem_be[0]) mem[mem_addr][7:0]  = mem_din[7:0];
    end
  end

  always @(negedge clk) begin
    if (vid_miss0) miss0_cnt++;
    if (cpu_ack) ack_cnt++;
  end

  function automatic logic [15:0] pat(input logic [13:0] a);
    return ({2'b00, a} * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_vid_dout"},  32'(vid_dout),  32'd0);
    check({pfx, "_vid_valid"}, 32'(vid_valid), 32'd0);
    check({pfx, "_vid_miss"},  32'(vid_miss),  32'd0);
    check({pfx, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({pfx, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    check({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    check({pfx, "_mem_be"},    32'(mem_be),    32'd0);
    check({pfx, "_mem_din"},   32'(mem_din),   32'd0);
  endtask

  task automatic wait_ack(input int max, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!cpu_ack && cyc < max);
  endtask

  // Per-cycle scoreboard for the random phase.
  task automatic observe();
    logic [13:0] a;
    check("both_retire", 32'(vid_valid & cpu_ack), 32'd0);
    if (vid_miss) begin
      check("miss_cpu_pend", 32'(cpu_pend), 32'd1);
      check("miss_queue", 32'(vq.size() > 0), 32'd1);
      if (vq.size() > 0) vq.delete(vq.size() - 1);
    end
    if (vid_valid) begin
      check("vid_queue", 32'(vq.size() > 0), 32'd1);
      if (vq.size() > 0) begin
        a = vq.pop_front();
        check("vid_data", 32'(vid_dout), 32'(pat(a)));
      end
    end
    if (cpu_pend) lat++;
    if (cpu_ack) begin
      check("ack_pend", 32'(cpu_pend), 32'd1);
      check("ack_latency", 32'(lat <= STARVE + 3), 32'd1);
      if (c_we) begin
        if (cpu_be[1]) shadow[c_idx][15:8] = cpu_wdata[15:8];
        if (cpu_be[0]) shadow[c_idx][7:0]  = cpu_wdata[7:0];
      end else begin
        check("cpu_rdata", 32'(cpu_rdata), 32'(shadow[c_idx]));
      end
      cpu_pend = 1'b0;
      cpu_req  = 1'b0;
      acked    = 1'b1;
    end else if (cpu_pend && lat > 40) begin
      check("cpu_timeout", 32'(lat), 32'(STARVE + 3));
      cpu_pend = 1'b0;
      cpu_req  = 1'b0;
    end
  endtask

  initial begin
    int n, a0, k0, miss_n, miss_at, cpu_at, ack_at, vv_after, post, pct;
    logic [15:0] rd;

    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_be = '0; cpu_addr = '0; cpu_wdata = '0; mem_dout0 = '0;
    for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
    for (int i = 0; i < 16; i++) shadow[i] = pat({10'h200, 4'(i)});
    mem[14'h0100] = 16'hA5A5; mem[14'h0001] = 16'h1111; mem[14'h0200] = 16'h2222;
    mem[14'h0002] = 16'h2B2B; mem[14'h1234] = 16'h1357; mem[14'h0300] = 16'h0F0F;
    mem[14'h0400] = 16'hAAAA; mem[14'h0500] = 16'h4321;

    repeat (3) step();
    check_idle("rst");
    reset = 1'b0;
    step();

    // Video read
    vid_req = 1'b1; vid_addr = 14'h0100;
    step(); vid_req = 1'b0;
    check("t1_mem_addr", 32'(mem_addr), 32'h0100);
    check("t1_mem_be", 32'(mem_be), 32'd3);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    step();
    check("t1_valid_early", 32'(vid_valid), 32'd0);
    check("t1_idle_be", 32'(mem_be), 32'd0);
    step();
    check("t1_valid", 32'(vid_valid), 32'd1);
    check("t1_dout", 32'(vid_dout), 32'hA5A5);
    step();
    check("t1_valid_pulse", 32'(vid_valid), 32'd0);
    check("t1_dout_hold", 32'(vid_dout), 32'hA5A5);

    // CPU high-byte write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b10; cpu_addr = 14'h1234; cpu_wdata = 16'hBEEF;
    step();
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_be", 32'(mem_be), 32'd2);
    check("t2_mem_addr", 32'(mem_addr), 32'h1234);
    check("t2_mem_din", 32'(mem_din), 32'hBEEF);
    step();
    check("t2_we_pulse", 32'(mem_we), 32'd0);
    check("t2_ack_early", 32'(cpu_ack), 32'd0);
    step();
    check("t2_ack", 32'(cpu_ack), 32'd1);
    check("t2_rdata_untouched", 32'(cpu_rdata), 32'd0);
    check("t2_mem_word", 32'(mem[14'h1234]), 32'hBE57);
    cpu_req = 1'b0;
    step();
    check("t2_ack_pulse", 32'(cpu_ack), 32'd0);

    // Simultaneous video and CPU read
    vid_req = 1'b1; vid_addr = 14'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 14'h0001;
    step(); vid_req = 1'b0;
    check("t3_vid_first", 32'(mem_addr), 32'h0200);
    step();
    check("t3_cpu_next", 32'(mem_addr), 32'h0001);
    step();
    check("t3_vid_valid", 32'(vid_valid), 32'd1);
    check("t3_vid_dout", 32'(vid_dout), 32'h2222);
    check("t3_ack_not_yet", 32'(cpu_ack), 32'd0);
    step();
    check("t3_ack", 32'(cpu_ack), 32'd1);
    check("t3_rdata", 32'(cpu_rdata), 32'h1111);
    check("t3_vid_valid_low", 32'(vid_valid), 32'd0);
    check("t3_vid_dout_hold", 32'(vid_dout), 32'h2222);
    cpu_req = 1'b0;
    step();

    // Starvation guard under continuous video
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 14'h0002;
    vid_req = 1'b1; vid_addr = 14'h3000;
    miss_n = 0; miss_at = 0; cpu_at = 0; ack_at = 0; vv_after = 0; rd = '0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (vid_miss) begin miss_n++; miss_at = c; end
      if (mem_addr == 14'h0002 && mem_be != 2'b00) cpu_at = c;
      if (cpu_ack) begin ack_at = c; rd = cpu_rdata; cpu_req = 1'b0; end
      if (vid_valid && c > 19) vv_after++;
      vid_addr = vid_addr + 14'd1;
    end
    vid_req = 1'b0;
    check("t4_miss_count", 32'(miss_n), 32'd1);
    check("t4_miss_cycle", 32'(miss_at), 32'd17);
    check("t4_cpu_issue_cycle", 32'(cpu_at), 32'd17);
    check("t4_ack_cycle", 32'(ack_at), 32'd19);
    check("t4_rdata", 32'(rd), 32'h2B2B);
    check("t4_video_resumes", 32'(vv_after), 32'd5);
    repeat (4) step();

    // Reset one cycle after a CPU issue
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 14'h0300; cpu_wdata = 16'h7777;
    step();
    check("t5_issue", 32'(mem_we), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    step();
    check_idle("t5_rst");
    step();
    reset = 1'b0;
    post = 0;
    repeat (5) begin
      step();
      if (cpu_ack || vid_valid) post++;
    end
    check("t5_no_stale_retire", 32'(post), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 14'h0001;
    wait_ack(8, n);
    check("t5_next_latency", 32'(n), 32'd3);
    check("t5_next_rdata", 32'(cpu_rdata), 32'h1111);
    cpu_req = 1'b0;
    step();

    // cpu_req held through the ack cycle
    a0 = mem_accesses; k0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01; cpu_addr = 14'h0400; cpu_wdata = 16'h12CD;
    wait_ack(8, n);
    check("t6_latency", 32'(n), 32'd3);
    step();
    cpu_req = 1'b0;
    repeat (4) step();
    check("t6_one_access", 32'(mem_accesses - a0), 32'd1);
    check("t6_one_ack", 32'(ack_cnt - k0), 32'd1);
    check("t6_mem_word", 32'(mem[14'h0400]), 32'hAACD);

    // Write with no byte lanes enabled
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b00; cpu_addr = 14'h0500; cpu_wdata = 16'hFFFF;
    wait_ack(8, n);
    check("t7_be0_ack", 32'(cpu_ack), 32'd1);
    check("t7_be0_latency", 32'(n), 32'd3);
    cpu_req = 1'b0;
    step();
    check("t7_be0_unchanged", 32'(mem[14'h0500]), 32'h4321);
    repeat (2) step();

    // Random traffic: video region 0x3000-0x30FF, CPU region 0x2000-0x200F
    for (int c = 0; c < 1300; c++) begin
      step();
      acked = 1'b0;
      observe();
      pct = (c < 600) ? 95 : 50;
      if (c < 1200 && $urandom_range(99) < pct) begin
        vid_req  = 1'b1;
        vid_addr = 14'h3000 | 14'($urandom_range(255));
        vq.push_back(vid_addr);
      end else begin
        vid_req = 1'b0;
      end
      if (c < 1200 && !cpu_pend && !acked && $urandom_range(3) == 0) begin
        c_idx     = 4'($urandom_range(15));
        cpu_we    = 1'($urandom_range(1));
        cpu_be    = 2'($urandom_range(3));
        cpu_wdata = 16'($urandom);
        cpu_addr  = {10'h200, c_idx};
        c_we      = cpu_we;
        cpu_req   = 1'b1;
        cpu_pend  = 1'b1;
        lat       = 0;
      end
    end
    check("rand_vq_drained", 32'(vq.size()), 32'd0);
    check("rand_cpu_drained", 32'(cpu_pend), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("rand_mem_final", 32'(mem[{10'h200, 4'(i)}]), 32'(shadow[i]));
    end
    check("limit0_no_miss", 32'(miss0_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
